// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command framing path: deframer state
// encoding, frame geometry, the default sync marker and the frame checksum.
package uart_cmd_pkg;

    // Deframer position within a 5-byte frame.
    typedef enum logic [2:0] {
        SYNC = 3'd0,
        CMD  = 3'd1,
        DHI  = 3'd2,
        DLO  = 3'd3,
        CHK  = 3'd4
    } deframe_state_t;

    // sync + command + data high + data low + checksum
    localparam int unsigned FRAME_LEN = 5;

    // Default frame start marker.
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    // Frame checksum: one's complement of the mod-256 sum of the payload.
    // Used by both the transmit-side framer and the receive-side deframer.
    function automatic logic [7:0] frame_chk(
        input logic [7:0] cmd,
        input logic [7:0] hi,
        input logic [7:0] lo
    );
        logic [7:0] sum;
        sum = cmd + hi + lo;
        return ~sum;
    endfunction

endpackage : uart_cmd_pkg

// File: rtl/byte_timeout_tmr.sv
// Inter-byte timeout timer for serial deframers.
// Counts enabled clocks since the last clear; raises tc combinationally in
// the cycle the count sits at TIMEOUT_CLKS-1 with no clear pending, and
// restarts from zero on that same edge.
module byte_timeout_tmr #(
    parameter int unsigned TIMEOUT_CLKS = 104160
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned       CNT_W  = $clog2(TIMEOUT_CLKS);
    localparam logic [CNT_W-1:0]  TC_VAL = CNT_W'(TIMEOUT_CLKS - 1);
    localparam logic [CNT_W-1:0]  ONE    = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Terminal count and next count: a clear always beats the terminal count
    // so a byte landing on the last cycle keeps the frame alive.
    always_comb begin
        tc    = en && !clr && (cnt_q == TC_VAL);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (tc) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : byte_timeout_tmr

// File: rtl/uart_cmd_deframer.sv
// UART command deframer: hunts for SYNC_BYTE, collects command and 16-bit
// operand, verifies the checksum and presents the result with a sticky ready
// flag. Partial frames are dropped when the inter-byte gap exceeds
// TIMEOUT_CLKS clocks.
import uart_cmd_pkg::*;

module uart_cmd_deframer #(
    parameter logic [7:0]  SYNC_BYTE    = DEF_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CLKS = 104160
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rdy,
    input  logic        clr_cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    output logic        frm_err,
    output logic        ovr_err
);

    deframe_state_t state_q, state_d;

    // Frame being assembled.
    logic [7:0]  cmd_byte_q, cmd_byte_d;
    logic [7:0]  dhi_q, dhi_d;
    logic [7:0]  dlo_q, dlo_d;

    // Published (validated) frame and status pulses.
    logic [7:0]  cmd_out_q, cmd_out_d;
    logic [15:0] data_out_q, data_out_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        frm_err_q, frm_err_d;
    logic        ovr_err_q, ovr_err_d;

    logic        tmo_clr;
    logic        tmo_en;
    logic        tmo_tc;
    logic [7:0]  exp_chk;

    // Every byte is acknowledged in the cycle it is presented.
    assign clr_rdy = rx_rdy;

    // Timer restarts on each consumed byte and is held idle while hunting.
    assign tmo_clr = rx_rdy || (state_q == SYNC);
    assign tmo_en  = (state_q != SYNC);

    byte_timeout_tmr #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmo_clr),
        .en    (tmo_en),
        .tc    (tmo_tc)
    );

    assign exp_chk = frame_chk(cmd_byte_q, dhi_q, dlo_q);

    // Next-state logic: byte consumption first, otherwise inter-byte timeout.
    always_comb begin
        state_d    = state_q;
        cmd_byte_d = cmd_byte_q;
        dhi_d      = dhi_q;
        dlo_d      = dlo_q;
        cmd_out_d  = cmd_out_q;
        data_out_d = data_out_q;
        frm_err_d  = 1'b0;
        ovr_err_d  = 1'b0;
        // Acknowledge clears; a frame completing this cycle re-sets below.
        cmd_rdy_d  = cmd_rdy_q && !clr_cmd_rdy;

        if (rx_rdy) begin
            case (state_q)
                SYNC: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = CMD;
                    end
                end
                CMD: begin
                    cmd_byte_d = rx_data;
                    state_d    = DHI;
                end
                DHI: begin
                    dhi_d   = rx_data;
                    state_d = DLO;
                end
                DLO: begin
                    dlo_d   = rx_data;
                    state_d = CHK;
                end
                CHK: begin
                    // The byte here is only ever a checksum, even if it
                    // happens to equal SYNC_BYTE.
                    if (rx_data == exp_chk) begin
                        cmd_out_d  = cmd_byte_q;
                        data_out_d = {dhi_q, dlo_q};
                        cmd_rdy_d  = 1'b1;
                        ovr_err_d  = cmd_rdy_q;
                    end else begin
                        frm_err_d  = 1'b1;
                    end
                    state_d = SYNC;
                end
                default: begin
                    state_d = SYNC;
                end
            endcase
        end else if (tmo_tc) begin
            state_d   = SYNC;
            frm_err_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SYNC;
            cmd_byte_q <= '0;
            dhi_q      <= '0;
            dlo_q      <= '0;
            cmd_out_q  <= '0;
            data_out_q <= '0;
            cmd_rdy_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            ovr_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_byte_q <= cmd_byte_d;
            dhi_q      <= dhi_d;
            dlo_q      <= dlo_d;
            cmd_out_q  <= cmd_out_d;
            data_out_q <= data_out_d;
            cmd_rdy_q  <= cmd_rdy_d;
            frm_err_q  <= frm_err_d;
            ovr_err_q  <= ovr_err_d;
        end
    end

    assign cmd     = cmd_out_q;
    assign data    = data_out_q;
    assign cmd_rdy = cmd_rdy_q;
    assign frm_err = frm_err_q;
    assign ovr_err = ovr_err_q;

endmodule : uart_cmd_deframer

// File: tb/tb_uart_cmd_deframer.sv
// Bench for uart_cmd_deframer: directed scenarios followed by random byte
// streams, every cycle compared against a frame-level reference model.
import uart_cmd_pkg::*;

module tb_uart_cmd_deframer;

    localparam int unsigned T    = 20;
    localparam logic [7:0]  SYNC_B = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_rdy = 1'b0;
    logic        clr_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        frm_err;
    logic        ovr_err;

    int checks = 0;
    int errors = 0;

    // Reference model state: bytes of the frame in progress, edge bookkeeping
    // for the inter-byte gap, and the expected published outputs.
    logic [7:0]  fq[$];
    longint      edge_n = 0;
    longint      last_edge = 0;
    logic [7:0]  m_cmd = 8'h00;
    logic [15:0] m_data = 16'h0000;
    logic        m_rdy = 1'b0;
    logic        m_frm = 1'b0;
    logic        m_ovr = 1'b0;

    uart_cmd_deframer #(
        .SYNC_BYTE    (SYNC_B),
        .TIMEOUT_CLKS (T)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .clr_rdy     (clr_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd         (cmd),
        .data        (data),
        .cmd_rdy     (cmd_rdy),
        .frm_err     (frm_err),
        .ovr_err     (ovr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model one clock edge given the inputs presented on it.
    task automatic model_edge(input logic rdy, input logic [7:0] d, input logic clr);
        logic nxt_rdy;
        m_frm   = 1'b0;
        m_ovr   = 1'b0;
        nxt_rdy = m_rdy && !clr;
        if (fq.size() != 0 && !rdy && (edge_n - last_edge) == longint'(T)) begin
            fq.delete();
            m_frm = 1'b1;
        end
        if (rdy) begin
            if (fq.size() == 0) begin
                if (d == SYNC_B) fq.push_back(d);
            end else begin
                fq.push_back(d);
            end
            last_edge = edge_n;
            if (fq.size() == FRAME_LEN) begin
                if (fq[4] == frame_chk(fq[1], fq[2], fq[3])) begin
                    m_ovr   = m_rdy;
                    m_cmd   = fq[1];
                    m_data  = {fq[2], fq[3]};
                    nxt_rdy = 1'b1;
                end else begin
                    m_frm = 1'b1;
                end
                fq.delete();
            end
        end
        m_rdy = nxt_rdy;
        edge_n++;
    endtask

    task automatic model_reset();
        fq.delete();
        m_cmd  = 8'h00;
        m_data = 16'h0000;
        m_rdy  = 1'b0;
        m_frm  = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // One clock: drive at negedge, check handshake, clock, check outputs.
    task automatic tick(input logic rdy, input logic [7:0] d, input logic clr);
        rx_rdy      = rdy;
        rx_data     = d;
        clr_cmd_rdy = clr;
        #1;
        chk("clr_rdy", {31'd0, clr_rdy}, {31'd0, rdy});
        @(posedge clk);
        model_edge(rdy, d, clr);
        @(negedge clk);
        rx_rdy      = 1'b0;
        clr_cmd_rdy = 1'b0;
        chk("cmd",     {24'd0, cmd},     {24'd0, m_cmd});
        chk("data",    {16'd0, data},    {16'd0, m_data});
        chk("cmd_rdy", {31'd0, cmd_rdy}, {31'd0, m_rdy});
        chk("frm_err", {31'd0, frm_err}, {31'd0, m_frm});
        chk("ovr_err", {31'd0, ovr_err}, {31'd0, m_ovr});
        $display("cyc %0d rdy=%0b d=%02h clr=%0b -> cmd=%02h data=%04h cmd_rdy=%0b frm=%0b ovr=%0b",
                 edge_n, rdy, d, clr, cmd, data, cmd_rdy, frm_err, ovr_err);
    endtask

    task automatic idle(input int n, input logic rand_clr);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 8'h00, rand_clr ? ($urandom_range(0, 3) == 0) : 1'b0);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap, input logic clr);
        idle(gap, 1'b0);
        tick(1'b1, b, clr);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] hi, input logic [7:0] lo,
                              input logic [7:0] ck, input logic clr_last);
        send(SYNC_B, 1, 1'b0);
        send(c, 1, 1'b0);
        send(hi, 1, 1'b0);
        send(lo, 1, 1'b0);
        send(ck, 1, clr_last);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_cmd", {24'd0, cmd}, 32'd0);
        chk("rst_data", {16'd0, data}, 32'd0);
        chk("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        chk("rst_clr_rdy", {31'd0, clr_rdy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Basic valid frame
        send_frame(8'h10, 8'h12, 8'h34, 8'hA9, 1'b0);
        chk("frmA_cmd", {24'd0, cmd}, 32'h10);
        chk("frmA_data", {16'd0, data}, 32'h1234);
        chk("frmA_rdy", {31'd0, cmd_rdy}, 32'd1);
        chk("frmA_err", {31'd0, frm_err}, 32'd0);
        tick(1'b0, 8'h00, 1'b1);
        chk("ack_clears", {31'd0, cmd_rdy}, 32'd0);

        // Junk before a frame
        send(8'h00, 0, 1'b0);
        send(8'hFF, 0, 1'b0);
        send(8'h5A, 0, 1'b0);
        send_frame(8'h01, 8'h00, 8'h02, 8'hFC, 1'b0);
        chk("junk_cmd", {24'd0, cmd}, 32'h01);
        chk("junk_data", {16'd0, data}, 32'h0002);
        tick(1'b0, 8'h00, 1'b1);

        // Bad checksum then recovery
        send_frame(8'h10, 8'h12, 8'h34, 8'h00, 1'b0);
        chk("bad_frm_err", {31'd0, frm_err}, 32'd1);
        chk("bad_rdy", {31'd0, cmd_rdy}, 32'd0);
        send_frame(8'h20, 8'h00, 8'h00, 8'hDF, 1'b0);
        chk("rec_cmd", {24'd0, cmd}, 32'h20);
        tick(1'b0, 8'h00, 1'b1);

        // Timeout abandons partial frame
        send(SYNC_B, 0, 1'b0);
        send(8'h10, 0, 1'b0);
        idle(int'(T) + 2, 1'b0);
        send_frame(8'h20, 8'h00, 8'h00, 8'hDF, 1'b0);
        chk("tmo_rec_rdy", {31'd0, cmd_rdy}, 32'd1);
        tick(1'b0, 8'h00, 1'b1);

        // Byte lands exactly on the terminal-count cycle
        send(SYNC_B, 0, 1'b0);
        send(8'h10, 0, 1'b0);
        send(8'h12, int'(T) - 1, 1'b0);
        chk("tc_edge_no_err", {31'd0, frm_err}, 32'd0);
        send(8'h34, 0, 1'b0);
        send(8'hA9, 0, 1'b0);
        chk("tc_edge_rdy", {31'd0, cmd_rdy}, 32'd1);
        tick(1'b0, 8'h00, 1'b1);

        // Overrun, back-to-back, and ack colliding with completion
        send_frame(8'h31, 8'h11, 8'h22, frame_chk(8'h31, 8'h11, 8'h22), 1'b0);
        send_frame(8'h32, 8'h33, 8'h44, frame_chk(8'h32, 8'h33, 8'h44), 1'b0);
        chk("ovr_pulse", {31'd0, ovr_err}, 32'd1);
        chk("ovr_cmd", {24'd0, cmd}, 32'h32);
        send_frame(8'h35, 8'h55, 8'h66, frame_chk(8'h35, 8'h55, 8'h66), 1'b1);
        chk("set_wins", {31'd0, cmd_rdy}, 32'd1);
        tick(1'b0, 8'h00, 1'b1);

        // Asynchronous reset mid-frame
        send(SYNC_B, 0, 1'b0);
        send(8'h10, 0, 1'b0);
        send(8'h12, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_cmd", {24'd0, cmd}, 32'd0);
        chk("arst_data", {16'd0, data}, 32'd0);
        chk("arst_rdy", {31'd0, cmd_rdy}, 32'd0);
        chk("arst_clr_rdy", {31'd0, clr_rdy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h10, 8'h12, 8'h34, 8'hA9, 1'b0);
        chk("post_rst_cmd", {24'd0, cmd}, 32'h10);

        // Random streams
        for (int it = 0; it < 300; it++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            if (kind < 3) begin
                send(8'($urandom), int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0));
            end else begin
                logic [7:0] c, hi, lo, ck;
                c  = 8'($urandom);
                hi = 8'($urandom);
                lo = 8'($urandom);
                ck = frame_chk(c, hi, lo);
                if ($urandom_range(0, 4) == 0) ck = ck ^ 8'($urandom_range(1, 255));
                send(SYNC_B, int'($urandom_range(0, 2)), 1'b0);
                for (int b = 0; b < 4; b++) begin
                    int g;
                    logic [7:0] v;
                    case ($urandom_range(0, 9))
                        0:       g = int'(T) - 1;
                        1:       g = int'(T);
                        2:       g = int'(T) + 1;
                        default: g = int'($urandom_range(0, 2));
                    endcase
                    v = (b == 0) ? c : (b == 1) ? hi : (b == 2) ? lo : ck;
                    send(v, g, ($urandom_range(0, 3) == 0));
                end
            end
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule : tb_uart_cmd_deframer
